rfdc_burst_scheduler: RTL and testbench

//   Sequences the enable input of the RFDC sine-tone AXIS driver into programmable bursts.

---
 rtl/rfdc_burst_scheduler.sv | 122 ++++++++++++
 tb/tb_rfdc_burst_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rfdc_burst_scheduler.sv
// Gates the RFDC tone driver enable into bursts of N accepted beats separated by G idle cycles,
// repeated B times or continuously, with exact beat accounting against the driver's tready.
module rfdc_burst_scheduler #(
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] cfg_burst_len,
  input  logic [GAP_WIDTH-1:0] cfg_gap_len,
  input  logic [CNT_WIDTH-1:0] cfg_num_bursts,
  input  logic                 drv_tready,
  output logic                 drv_enable,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] bursts_done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state, state_n;

  logic [LEN_WIDTH-1:0] len_q, beat_cnt;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [CNT_WIDTH-1:0] num_q;

  logic accept, last_beat, last_burst, launch, reject;

  // drv_enable is high exactly while in BURST, so accept implies state==BURST
  assign accept     = drv_enable & drv_tready;
  assign last_beat  = accept && (beat_cnt == len_q - LEN_ONE);
  assign last_burst = (num_q != '0) && (bursts_done + CNT_ONE == num_q);

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_burst_len == '0) begin
            reject = 1'b1;
          end else begin
            launch  = 1'b1;
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (abort)               state_n = IDLE;
        else if (last_beat) begin
          if (last_burst)        state_n = DONE;
          else if (gap_q == '0)  state_n = BURST;
          else                   state_n = GAP;
        end
      end
      GAP: begin
        if (abort)                           state_n = IDLE;
        else if (gap_cnt == gap_q - GAP_ONE) state_n = BURST;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      drv_enable <= (state_n == BURST);
      busy       <= (state_n == BURST) || (state_n == GAP);
      done       <= (state_n == DONE);
      cfg_err    <= reject;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      bursts_done <= '0;
    end else begin
      if (launch) begin
        len_q       <= cfg_burst_len;
        gap_q       <= cfg_gap_len;
        num_q       <= cfg_num_bursts;
        beat_cnt    <= '0;
        bursts_done <= '0;
      end else if (accept) begin
        // a beat taken during abort is counted but never closes a burst
        if (last_beat && !abort) begin
          beat_cnt    <= '0;
          bursts_done <= bursts_done + CNT_ONE;
        end else begin
          beat_cnt <= beat_cnt + LEN_ONE;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_ONE : '0;
    end
  end

endmodule

// File: tb/tb_rfdc_burst_scheduler.sv
// Self-checking bench: table of burst configs replayed against a cycle scoreboard,
// plus hand sequences for reject, abort, wrap, async reset and mid-sequence start.
module tb_rfdc_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, drv_tready;
  logic [15:0] cfg_burst_len, cfg_gap_len;
  logic [7:0]  cfg_num_bursts;
  logic        drv_enable, busy, done, cfg_err;
  logic [7:0]  bursts_done;

  int total = 0;
  int passed = 0;

  rfdc_burst_scheduler #(.LEN_WIDTH(16), .GAP_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_burst_len(cfg_burst_len), .cfg_gap_len(cfg_gap_len), .cfg_num_bursts(cfg_num_bursts),
    .drv_tready(drv_tready), .drv_enable(drv_enable), .busy(busy), .done(done),
    .bursts_done(bursts_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [15:0] gap;
    logic [7:0]  num;
    int          mode;      // 0: tready always 1, 1: tready 1,0,1,0 from first enable cycle
    int          exp_beats;
    int          exp_done_cyc;
    logic [7:0]  exp_bd;
  } vec_t;

  typedef struct packed {
    logic       en;
    logic       bsy;
    logic       dn;
    logic [7:0] bd;
  } obs_t;

  vec_t tbl[5];
  obs_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic trdy(input int mode, input int k);
    return (mode == 0) ? 1'b1 : (k % 2 == 0);
  endfunction

  // Expected waveform from the first enable cycle: bursts of len accepted beats, gaps, done, idle.
  task automatic build(input vec_t v);
    int k = 0;
    logic [7:0] bd = 0;
    for (int b = 0; b < v.num; b++) begin
      int beats = 0;
      while (beats < v.len) begin
        sb.push_back('{1'b1, 1'b1, 1'b0, bd});
        if (trdy(v.mode, k)) beats++;
        k++;
      end
      bd++;
      if (b < v.num - 1)
        for (int g = 0; g < v.gap; g++) begin
          sb.push_back('{1'b0, 1'b1, 1'b0, bd});
          k++;
        end
    end
    sb.push_back('{1'b0, 1'b0, 1'b1, bd});
    sb.push_back('{1'b0, 1'b0, 1'b0, bd});
  endtask

  // poke: re-pulse start with a different config while busy; it must be ignored
  task automatic run(input vec_t v, input bit poke);
    int k = 0;
    int beats = 0;
    int done_cyc = -1;
    obs_t exp, act;
    sb.delete();
    build(v);
    cfg_burst_len = v.len; cfg_gap_len = v.gap; cfg_num_bursts = v.num;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_burst_len = 16'($urandom_range(1, 9));
    cfg_gap_len   = 16'($urandom_range(0, 9));
    cfg_num_bursts = 8'($urandom_range(0, 9));
    while (sb.size() > 0 && k < 400) begin
      start = poke && (k == 1);
      drv_tready = trdy(v.mode, k);
      exp = sb.pop_front();
      act = '{drv_enable, busy, done, bursts_done};
      chk("cycle", 32'(act), 32'(exp));
      if (drv_enable && drv_tready) beats++;
      if (done && done_cyc < 0) done_cyc = k + 1;
      tick();
      k++;
    end
    start = 1'b0;
    chk("run_bound", 32'(sb.size()), 32'd0);
    chk("beats", 32'(beats), 32'(v.exp_beats));
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
    chk("bursts_done", 32'(bursts_done), 32'(v.exp_bd));
  endtask

  initial begin
    int n, beats;
    bit seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; drv_tready = 1'b0;
    cfg_burst_len = '0; cfg_gap_len = '0; cfg_num_bursts = '0;

    tbl[0] = '{16'd4, 16'd3, 8'd2, 0, 8,  12, 8'd2};
    tbl[1] = '{16'd3, 16'd0, 8'd1, 1, 3,  6,  8'd1};
    tbl[2] = '{16'd2, 16'd0, 8'd3, 0, 6,  7,  8'd3};
    tbl[3] = '{16'd1, 16'd1, 8'd2, 0, 2,  4,  8'd2};
    tbl[4] = '{16'd3, 16'd2, 8'd2, 1, 6,  14, 8'd2};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", {27'd0, drv_enable, busy, done, cfg_err, 1'b0}, 32'd0);
    chk("reset_bd", 32'(bursts_done), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      run(tbl[i], 1'b0);
      tick();
    end

    // continuous mode, abort right after the 2nd beat of burst 4
    cfg_burst_len = 16'd5; cfg_gap_len = 16'd2; cfg_num_bursts = 8'd0; drv_tready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    beats = 0; n = 0;
    while (beats < 17 && n < 200) begin
      if (drv_enable) beats++;
      tick(); n++;
    end
    chk("abort_reach", 32'(beats), 32'd17);
    chk("abort_pre_en", 32'(drv_enable), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_en_busy", {30'd0, drv_enable, busy}, 32'd0);
    chk("abort_bd", 32'(bursts_done), 32'd3);
    seen = done;
    repeat (3) begin tick(); seen |= done; end
    chk("abort_no_done", 32'(seen), 32'd0);

    // start together with abort in IDLE does nothing
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {30'd0, busy, drv_enable}, 32'd0);
    chk("start_abort_bd", 32'(bursts_done), 32'd3);
    tick();

    // bursts_done wraps modulo 256 in continuous mode (len 1, no gap)
    cfg_burst_len = 16'd1; cfg_gap_len = 16'd0; cfg_num_bursts = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap_start_bd", 32'(bursts_done), 32'd0);
    repeat (257) tick();
    chk("wrap_bd", 32'(bursts_done), 32'd1);
    chk("wrap_en", 32'(drv_enable), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("wrap_abort_bd", 32'(bursts_done), 32'd1);
    tick();

    // zero length start is rejected with a single cfg_err pulse
    cfg_burst_len = 16'd0; cfg_gap_len = 16'd0; cfg_num_bursts = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("len0_err", {29'd0, cfg_err, busy, drv_enable}, 32'h4);
    chk("len0_bd_held", 32'(bursts_done), 32'd1);
    tick();
    chk("len0_err_clr", {29'd0, cfg_err, busy, drv_enable}, 32'h0);

    // async reset between edges mid-burst
    cfg_burst_len = 16'd10; cfg_num_bursts = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_en", 32'(drv_enable), 32'd1);
    #3 rst = 1'b1;
    #1 chk("async_rst", {29'd0, drv_enable, busy, done}, 32'd0);
    chk("async_rst_bd", 32'(bursts_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // start pulsed mid-sequence with new config must not disturb the latched one
    run('{16'd4, 16'd0, 8'd1, 0, 4, 5, 8'd1}, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
